// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that writes little-endian words into instruction memory and holds the core in reset until a load succeeds
// Optional checksum byte after the data is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 65535,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int IW = $clog2(DEPTH + 1);
  localparam logic [31:0] DEP = 32'(DEPTH);
  localparam logic [31:0] TO = 32'(TIMEOUT);
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, FIN, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t state, state_n;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [IW-1:0] idx;
  logic [1:0]  bcnt;
  logic [31:0] word;
  logic [31:0] idle_cnt;
  logic        err_q, crst_q;
  logic        acc, last, len_bad, timed_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  assign in_ready = state inside {LEN_LO, LEN_HI, DATA, CHK};
`else
  assign in_ready = state inside {LEN_LO, LEN_HI, DATA};
`endif
  assign acc        = in_valid && in_ready;
  assign len_bad    = ({in_data, len_lo} == 16'd0) || ({16'd0, in_data, len_lo} > DEP);
  assign last       = 32'(idx) + 32'd1 >= {16'd0, len};
  // The idle counter only advances while a byte is being waited for.
  assign timed_out  = (TO != 32'd0) && in_ready && !acc && (idle_cnt + 32'd1 >= TO);
  assign imem_we    = state == WRITE;
  assign imem_addr  = BASE_ADDR + (32'(idx) << 2);
  assign imem_wdata = word;
  assign busy       = state != IDLE;
  assign done       = (state == FIN) || (state == ERR);
  assign error      = err_q;
  assign core_rst   = crst_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = start ? LEN_LO : IDLE;
      LEN_LO: state_n = acc ? LEN_HI : LEN_LO;
      LEN_HI: state_n = acc ? (len_bad ? ERR : DATA) : LEN_HI;
      DATA:   state_n = (acc && bcnt == 2'd3) ? WRITE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE:  state_n = last ? CHK : DATA;
      CHK:    state_n = acc ? ((in_data == csum) ? FIN : ERR) : CHK;
`else
      WRITE:  state_n = last ? FIN : DATA;
`endif
      default: state_n = IDLE;
    endcase
    if (timed_out) state_n = ERR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_lo   <= '0;
      len      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      word     <= '0;
      idle_cnt <= '0;
      err_q    <= 1'b0;
      crst_q   <= BOOT_HOLD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        idx      <= '0;
        bcnt     <= '0;
        idle_cnt <= '0;
        err_q    <= 1'b0;
        crst_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (acc) idle_cnt <= '0;
      else if (in_ready) idle_cnt <= idle_cnt + 32'd1;
      if (acc && state == LEN_LO) len_lo <= in_data;
      if (acc && state == LEN_HI) len <= {in_data, len_lo};
      // Shifting in from the top leaves byte0 in wdata[7:0] after four bytes.
      if (acc && state == DATA) begin
        word <= {in_data, word[31:8]};
        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
      end
      if (state == WRITE) idx <= idx + IW'(1);
      if (state_n == ERR) err_q <= 1'b1;
      if (state_n == FIN) crst_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard, plus reset, timeout and checksum sequences
module tb_imem_loader;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h100;
  localparam int TO = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 2;
`endif
  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, imem_we, core_rst, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] words [16];
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t q[$];
  typedef struct {int len; int nw; bit gap; bit exp_err;} vec_t;
  vec_t vt [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TO), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", imem_addr, e.addr);
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, BASE);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output int acc_cyc);
    int t;
    bit acc;
    t = 0;
    acc = 1'b0;
    acc_cyc = 0;
    if (gap) repeat ($urandom_range(1, 10)) tick();
    in_valid = 1'b1;
    in_data = b;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %h never accepted", b);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc, output bit seen);
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: done never pulsed", tag);
    end
  endtask

  task automatic run_load(input int len, input int nw, input bit gap, input bit exp_err,
                          input bit pre_started, input logic [7:0] cs_xor, input string tag);
    int c0, c, cd;
    bit seen;
    logic [7:0] cs, b;
    cs = 8'd0;
    if (!pre_started) do_start();
    chk({tag, "_err_cleared"}, {31'd0, error}, 32'd0);
    chk({tag, "_hold"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    send_byte(len[7:0], gap, c0);
    send_byte(len[15:8], gap, c);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[w][8*k +: 8];
        cs ^= b;
        if (k == 3) q.push_back('{addr: BASE + 32'(4 * w), data: words[w]});
        send_byte(b, gap, c);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nw > 0) send_byte(cs ^ cs_xor, gap, c);
`endif
    wait_done(tag, cd, seen);
    if (seen) begin
      chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
      chk({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, exp_err});
      if (!gap && !exp_err) chk({tag, "_latency"}, 32'(cd - c0), 32'(5 * nw + EXTRA));
    end
    chk({tag, "_pending"}, 32'(q.size()), 32'd0);
    tick();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int c, c5, cd;
    bit seen;
    vt[0] = '{len: 1, nw: 1, gap: 1'b0, exp_err: 1'b0};
    vt[1] = '{len: 3, nw: 3, gap: 1'b1, exp_err: 1'b0};
    vt[2] = '{len: 0, nw: 0, gap: 1'b0, exp_err: 1'b1};
    vt[3] = '{len: DEPTH + 1, nw: 0, gap: 1'b0, exp_err: 1'b1};
    vt[4] = '{len: DEPTH, nw: DEPTH, gap: 1'b0, exp_err: 1'b0};
    vt[5] = '{len: 3, nw: 3, gap: 1'b1, exp_err: 1'b0};
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    tick();
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    run_load(2, 2, 1'b0, 1'b0, 1'b0, 8'd0, "spec");
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 16; w++) words[w] = $urandom;
      run_load(vt[v].len, vt[v].nw, vt[v].gap, vt[v].exp_err, 1'b0, 8'd0, $sformatf("vec%0d", v));
    end
    // start with a byte offered in the same IDLE cycle: the byte must be refused
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAA;
    @(negedge clk);
    chk("start_byte_ready", {31'd0, in_ready}, 32'd0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    words[0] = 32'hCAFEF00D;
    run_load(1, 1, 1'b0, 1'b0, 1'b1, 8'd0, "samecyc");
    // reset in the middle of a load
    do_start();
    send_byte(8'd2, 1'b0, c);
    send_byte(8'd0, 1'b0, c);
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1'b0, c);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_hold", {31'd0, core_rst}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    // stall after the fifth byte until the idle timeout fires
    do_start();
    send_byte(8'd2, 1'b0, c);
    send_byte(8'd0, 1'b0, c);
    send_byte(8'h11, 1'b0, c);
    send_byte(8'h22, 1'b0, c);
    send_byte(8'h33, 1'b0, c5);
    wait_done("tmo", cd, seen);
    if (seen) begin
      chk("tmo_error", {31'd0, error}, 32'd1);
      chk("tmo_core_rst", {31'd0, core_rst}, 32'd1);
      chk("tmo_latency", 32'(cd - c5), 32'(TO + 1));
    end
    tick();
    words[0] = 32'h0BADC0DE;
    run_load(1, 1, 1'b0, 1'b0, 1'b0, 8'd0, "after_tmo");
`ifdef IMEM_LOADER_CHECKSUM_EN
    words[0] = 32'h04030201;
    run_load(1, 1, 1'b0, 1'b0, 1'b0, 8'd0, "cs_good");
    run_load(1, 1, 1'b0, 1'b1, 1'b0, 8'd1, "cs_bad");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
